// File: rtl/decode_stage.sv
// decode_stage: RV64 integer decode stage with a 32-entry register file,
// write-through bypass and a single valid/ready output register.
// Optional feature macro: RV_M_EXT_EN enables decoding of the M-extension
// multiply/divide encodings on OP and OP-32 (otherwise they decode as illegal).
module decode_stage #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               instr,
  input  logic                      wb_en,
  input  logic [4:0]                wb_rd,
  input  logic [BUS_DATA_WIDTH-1:0] wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BUS_DATA_WIDTH-1:0] dataA,
  output logic [BUS_DATA_WIDTH-1:0] dataB,
  output logic [5:0]                alu_control,
  output logic [4:0]                rd,
  output logic                      illegal
);

  localparam int W = BUS_DATA_WIDTH;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Source selection for operand B
  typedef enum logic [1:0] {
    SRC_RS2 = 2'd0,
    SRC_IMM = 2'd1,
    SRC_SH6 = 2'd2,
    SRC_SH5 = 2'd3
  } b_src_e;

  // Register file and output register state
  logic [W-1:0] regs_q [32];
  logic [W-1:0] regs_d [32];
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] data_a_q, data_a_d;
  logic [W-1:0] data_b_q, data_b_d;
  logic [5:0]   alu_control_q, alu_control_d;
  logic [4:0]   rd_q, rd_d;
  logic         illegal_q, illegal_d;

  // Instruction fields
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic [4:0] rd_s;

  logic [W-1:0] rs1_val_s;
  logic [W-1:0] rs2_val_s;
  logic [W-1:0] imm_s;
  logic [W-1:0] sh6_s;
  logic [W-1:0] sh5_s;

  logic [5:0]   dec_alu_s;
  logic         dec_legal_s;
  b_src_e       dec_bsrc_s;
  logic         transfer_s;

  assign opcode_s = instr[6:0];
  assign rd_s     = instr[11:7];
  assign funct3_s = instr[14:12];
  assign rs1_s    = instr[19:15];
  assign rs2_s    = instr[24:20];
  assign funct7_s = instr[31:25];

  assign imm_s = {{(W-12){instr[31]}}, instr[31:20]};
  assign sh6_s = {{(W-6){1'b0}}, instr[25:20]};
  assign sh5_s = {{(W-5){1'b0}}, instr[24:20]};

  assign in_ready    = !out_valid_q || out_ready;
  assign transfer_s  = in_valid && in_ready;

  assign out_valid   = out_valid_q;
  assign dataA       = data_a_q;
  assign dataB       = data_b_q;
  assign alu_control = alu_control_q;
  assign rd          = rd_q;
  assign illegal     = illegal_q;

  // rs1 read port: x0 reads zero, same-cycle write to rs1 is forwarded
  always_comb begin
    rs1_val_s = {W{1'b0}};
    if (rs1_s == 5'd0) begin
      rs1_val_s = {W{1'b0}};
    end else if (wb_en && (wb_rd == rs1_s)) begin
      rs1_val_s = wb_data;
    end else begin
      rs1_val_s = regs_q[rs1_s];
    end
  end

  // rs2 read port: x0 reads zero, same-cycle write to rs2 is forwarded
  always_comb begin
    rs2_val_s = {W{1'b0}};
    if (rs2_s == 5'd0) begin
      rs2_val_s = {W{1'b0}};
    end else if (wb_en && (wb_rd == rs2_s)) begin
      rs2_val_s = wb_data;
    end else begin
      rs2_val_s = regs_q[rs2_s];
    end
  end

  // Instruction decode: ALU opcode, legality and operand-B source
  always_comb begin
    dec_alu_s   = 6'd0;
    dec_legal_s = 1'b0;
    dec_bsrc_s  = SRC_IMM;
    case (opcode_s)
      OPC_OP_IMM: begin
        dec_bsrc_s = SRC_IMM;
        case (funct3_s)
          3'b000: begin dec_alu_s = 6'd1; dec_legal_s = 1'b1; end
          3'b010: begin dec_alu_s = 6'd2; dec_legal_s = 1'b1; end
          3'b011: begin dec_alu_s = 6'd3; dec_legal_s = 1'b1; end
          3'b100: begin dec_alu_s = 6'd4; dec_legal_s = 1'b1; end
          3'b110: begin dec_alu_s = 6'd5; dec_legal_s = 1'b1; end
          3'b111: begin dec_alu_s = 6'd6; dec_legal_s = 1'b1; end
          3'b001: begin
            dec_bsrc_s = SRC_SH6;
            if (instr[31:26] == 6'b000000) begin
              dec_alu_s = 6'd7; dec_legal_s = 1'b1;
            end else begin
              dec_legal_s = 1'b0;
            end
          end
          3'b101: begin
            dec_bsrc_s = SRC_SH6;
            if (instr[31:26] == 6'b000000) begin
              dec_alu_s = 6'd8; dec_legal_s = 1'b1;
            end else if (instr[31:26] == 6'b010000) begin
              dec_alu_s = 6'd9; dec_legal_s = 1'b1;
            end else begin
              dec_legal_s = 1'b0;
            end
          end
          default: dec_legal_s = 1'b0;
        endcase
      end
      OPC_OP: begin
        dec_bsrc_s = SRC_RS2;
        case (funct7_s)
          F7_BASE: begin
            dec_legal_s = 1'b1;
            case (funct3_s)
              3'b000:  dec_alu_s = 6'd12;
              3'b001:  dec_alu_s = 6'd14;
              3'b010:  dec_alu_s = 6'd15;
              3'b011:  dec_alu_s = 6'd16;
              3'b100:  dec_alu_s = 6'd17;
              3'b101:  dec_alu_s = 6'd18;
              3'b110:  dec_alu_s = 6'd20;
              3'b111:  dec_alu_s = 6'd21;
              default: dec_legal_s = 1'b0;
            endcase
          end
          F7_ALT: begin
            case (funct3_s)
              3'b000:  begin dec_alu_s = 6'd13; dec_legal_s = 1'b1; end
              3'b101:  begin dec_alu_s = 6'd19; dec_legal_s = 1'b1; end
              default: dec_legal_s = 1'b0;
            endcase
          end
          F7_MUL: begin
`ifdef RV_M_EXT_EN
            // mul, mulh, mulhsu, mulhu, div, divu, rem, remu follow funct3 order
            dec_alu_s   = 6'd31 + {3'b000, funct3_s};
            dec_legal_s = 1'b1;
`else
            dec_legal_s = 1'b0;
`endif
          end
          default: dec_legal_s = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        case (funct3_s)
          3'b000: begin
            dec_bsrc_s = SRC_IMM; dec_alu_s = 6'd22; dec_legal_s = 1'b1;
          end
          3'b001: begin
            dec_bsrc_s = SRC_SH5;
            if (funct7_s == F7_BASE) begin
              dec_alu_s = 6'd23; dec_legal_s = 1'b1;
            end else begin
              dec_legal_s = 1'b0;
            end
          end
          3'b101: begin
            dec_bsrc_s = SRC_SH5;
            if (funct7_s == F7_BASE) begin
              dec_alu_s = 6'd24; dec_legal_s = 1'b1;
            end else if (funct7_s == F7_ALT) begin
              dec_alu_s = 6'd25; dec_legal_s = 1'b1;
            end else begin
              dec_legal_s = 1'b0;
            end
          end
          default: dec_legal_s = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        dec_bsrc_s = SRC_RS2;
        case (funct7_s)
          F7_BASE: begin
            case (funct3_s)
              3'b000:  begin dec_alu_s = 6'd26; dec_legal_s = 1'b1; end
              3'b001:  begin dec_alu_s = 6'd28; dec_legal_s = 1'b1; end
              3'b101:  begin dec_alu_s = 6'd29; dec_legal_s = 1'b1; end
              default: dec_legal_s = 1'b0;
            endcase
          end
          F7_ALT: begin
            case (funct3_s)
              3'b000:  begin dec_alu_s = 6'd27; dec_legal_s = 1'b1; end
              3'b101:  begin dec_alu_s = 6'd30; dec_legal_s = 1'b1; end
              default: dec_legal_s = 1'b0;
            endcase
          end
          F7_MUL: begin
`ifdef RV_M_EXT_EN
            case (funct3_s)
              3'b000:  begin dec_alu_s = 6'd39; dec_legal_s = 1'b1; end
              3'b100:  begin dec_alu_s = 6'd40; dec_legal_s = 1'b1; end
              3'b101:  begin dec_alu_s = 6'd41; dec_legal_s = 1'b1; end
              3'b110:  begin dec_alu_s = 6'd42; dec_legal_s = 1'b1; end
              3'b111:  begin dec_alu_s = 6'd43; dec_legal_s = 1'b1; end
              default: dec_legal_s = 1'b0;
            endcase
`else
            dec_legal_s = 1'b0;
`endif
          end
          default: dec_legal_s = 1'b0;
        endcase
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // Output register next state: load on transfer, drop on consume, else hold
  always_comb begin
    out_valid_d   = out_valid_q;
    data_a_d      = data_a_q;
    data_b_d      = data_b_q;
    alu_control_d = alu_control_q;
    rd_d          = rd_q;
    illegal_d     = illegal_q;
    if (transfer_s) begin
      out_valid_d = 1'b1;
      if (dec_legal_s) begin
        alu_control_d = dec_alu_s;
        rd_d          = rd_s;
        illegal_d     = 1'b0;
        data_a_d      = rs1_val_s;
        case (dec_bsrc_s)
          SRC_RS2: data_b_d = rs2_val_s;
          SRC_IMM: data_b_d = imm_s;
          SRC_SH6: data_b_d = sh6_s;
          SRC_SH5: data_b_d = sh5_s;
          default: data_b_d = {W{1'b0}};
        endcase
      end else begin
        // Unsupported encodings still flow through the handshake as a bubble op
        alu_control_d = 6'd0;
        rd_d          = 5'd0;
        illegal_d     = 1'b1;
        data_a_d      = {W{1'b0}};
        data_b_d      = {W{1'b0}};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Register-file next state: one write port, x0 never written
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_en && (wb_rd != 5'd0)) begin
      regs_d[wb_rd] = wb_data;
    end else begin
      regs_d[0] = {W{1'b0}};
    end
  end

  // State update with synchronous reset clearing outputs and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      data_a_q      <= {W{1'b0}};
      data_b_q      <= {W{1'b0}};
      alu_control_q <= 6'd0;
      rd_q          <= 5'd0;
      illegal_q     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= {W{1'b0}};
      end
    end else begin
      out_valid_q   <= out_valid_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      alu_control_q <= alu_control_d;
      rd_q          <= rd_d;
      illegal_q     <= illegal_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed, table-driven bench for decode_stage.
// Honours RV_M_EXT_EN when choosing expectations for M-extension encodings.
module tb_decode_stage;

  localparam int W = 64;

  localparam logic [6:0] OPI   = 7'h13;
  localparam logic [6:0] OPR   = 7'h33;
  localparam logic [6:0] OPI32 = 7'h1B;
  localparam logic [6:0] OPR32 = 7'h3B;

  localparam logic [63:0] X1   = 64'h0000_0000_0000_1111;
  localparam logic [63:0] X2   = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [63:0] X5   = 64'h0000_0000_0000_0010;
  localparam logic [63:0] X9   = 64'h8000_0000_0000_0001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  instr;
  logic         wb_en;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic [5:0]   alu_control;
  logic [4:0]   rd;
  logic         illegal;

  int n_tests;
  int n_fail;
  int hs_cnt;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  alu;
    logic        ill;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  vec_t vecs[$];

  decode_stage #(.BUS_DATA_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dataA       (data_a),
    .dataB       (data_b),
    .alu_control (alu_control),
    .rd          (rd),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted outputs on the ALU side
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdi, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rdi, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdi,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rdi, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] i, input logic [5:0] alu, input logic ill,
                         input logic [4:0] r, input logic [63:0] a, input logic [63:0] b);
    vec_t v;
    v.instr = i; v.alu = alu; v.ill = ill; v.rd = r; v.a = a; v.b = b;
    vecs.push_back(v);
  endtask

  task automatic add_illegal(input logic [31:0] i);
    add_vec(i, 6'd0, 1'b1, 5'd0, 64'd0, 64'd0);
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  // Present one instruction with out_ready high and return after it is registered
  task automatic issue(input logic [31:0] i);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = i;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, ".alu"}, {58'd0, alu_control}, {58'd0, v.alu});
    chk({tag, ".illegal"}, {63'd0, illegal}, {63'd0, v.ill});
    chk({tag, ".rd"}, {59'd0, rd}, {59'd0, v.rd});
    if (!v.ill) begin
      chk({tag, ".dataA"}, data_a, v.a);
      chk({tag, ".dataB"}, data_b, v.b);
    end else begin
      chk({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hv;
    int   hs0;

    n_tests = 0; n_fail = 0; hs_cnt = 0;
    reset = 1'b1; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;

    // OP-IMM
    add_vec(enc_i(12'hFFF, 5'd5, 3'd0, 5'd6, OPI), 6'd1, 1'b0, 5'd6, X5, ONES);
    add_vec(enc_i(12'h005, 5'd1, 3'd2, 5'd7, OPI), 6'd2, 1'b0, 5'd7, X1, 64'd5);
    add_vec(enc_i(12'h7FF, 5'd9, 3'd3, 5'd14, OPI), 6'd3, 1'b0, 5'd14, X9, 64'h7FF);
    add_vec(enc_i(12'hF0F, 5'd1, 3'd4, 5'd15, OPI), 6'd4, 1'b0, 5'd15, X1, 64'hFFFF_FFFF_FFFF_FF0F);
    add_vec(enc_i(12'h800, 5'd9, 3'd6, 5'd11, OPI), 6'd5, 1'b0, 5'd11, X9, 64'hFFFF_FFFF_FFFF_F800);
    add_vec(enc_i(12'h7FF, 5'd2, 3'd7, 5'd10, OPI), 6'd6, 1'b0, 5'd10, X2, 64'h7FF);
    add_vec(enc_i(12'h03F, 5'd1, 3'd1, 5'd12, OPI), 6'd7, 1'b0, 5'd12, X1, 64'd63);
    add_vec(enc_i(12'h004, 5'd2, 3'd5, 5'd16, OPI), 6'd8, 1'b0, 5'd16, X2, 64'd4);
    add_vec(enc_i(12'h421, 5'd9, 3'd5, 5'd13, OPI), 6'd9, 1'b0, 5'd13, X9, 64'd33);
    add_illegal(enc_i(12'h821, 5'd9, 3'd5, 5'd13, OPI));
    // OP
    add_vec(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd18, OPR), 6'd12, 1'b0, 5'd18, 64'd0, 64'd0);
    add_vec(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, OPR), 6'd13, 1'b0, 5'd3, X1, X2);
    add_vec(enc_r(7'h00, 5'd9, 5'd2, 3'd3, 5'd20, OPR), 6'd16, 1'b0, 5'd20, X2, X9);
    add_vec(enc_r(7'h20, 5'd1, 5'd9, 3'd5, 5'd4, OPR), 6'd19, 1'b0, 5'd4, X9, X1);
    add_vec(enc_r(7'h00, 5'd5, 5'd9, 3'd6, 5'd21, OPR), 6'd20, 1'b0, 5'd21, X9, X5);
    add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd14, OPR), 6'd21, 1'b0, 5'd14, X1, X2);
    add_illegal(enc_r(7'h10, 5'd2, 5'd1, 3'd0, 5'd22, OPR));
    add_illegal(enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd22, OPR));
    // OP-IMM-32
    add_vec(enc_i(12'h001, 5'd2, 3'd0, 5'd15, OPI32), 6'd22, 1'b0, 5'd15, X2, 64'd1);
    add_vec(enc_i(12'h01F, 5'd1, 3'd1, 5'd16, OPI32), 6'd23, 1'b0, 5'd16, X1, 64'd31);
    add_vec(enc_i(12'h41F, 5'd9, 3'd5, 5'd17, OPI32), 6'd25, 1'b0, 5'd17, X9, 64'd31);
    add_illegal(enc_i(12'h020, 5'd1, 3'd1, 5'd16, OPI32));
    // OP-32
    add_vec(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd18, OPR32), 6'd27, 1'b0, 5'd18, X1, X2);
    add_vec(enc_r(7'h00, 5'd5, 5'd1, 3'd1, 5'd23, OPR32), 6'd28, 1'b0, 5'd23, X1, X5);
    add_vec(enc_r(7'h20, 5'd1, 5'd9, 3'd5, 5'd19, OPR32), 6'd30, 1'b0, 5'd19, X9, X1);
    add_illegal(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd22, OPR32));
    add_illegal(enc_r(7'h01, 5'd2, 5'd1, 3'd1, 5'd26, OPR32));
    add_illegal(32'h1234_50B7);
    // M-extension encodings
`ifdef RV_M_EXT_EN
    add_vec(enc_r(7'h01, 5'd3, 5'd2, 3'd0, 5'd1, OPR), 6'd31, 1'b0, 5'd1, X2, 64'd0);
    add_vec(enc_r(7'h01, 5'd5, 5'd9, 3'd7, 5'd24, OPR), 6'd38, 1'b0, 5'd24, X9, X5);
    add_vec(enc_r(7'h01, 5'd2, 5'd1, 3'd5, 5'd25, OPR32), 6'd41, 1'b0, 5'd25, X1, X2);
`else
    add_illegal(enc_r(7'h01, 5'd3, 5'd2, 3'd0, 5'd1, OPR));
    add_illegal(enc_r(7'h01, 5'd5, 5'd9, 3'd7, 5'd24, OPR));
    add_illegal(enc_r(7'h01, 5'd2, 5'd1, 3'd5, 5'd25, OPR32));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst.alu", {58'd0, alu_control}, 64'd0);
    chk("rst.dataA", data_a, 64'd0);

    // Register preload; the write to x0 must be ignored
    wb_write(5'd1, X1);
    wb_write(5'd2, X2);
    wb_write(5'd5, X5);
    wb_write(5'd9, X9);
    wb_write(5'd0, 64'hDEAD_BEEF);

    // Table-driven decode vectors
    foreach (vecs[k]) begin
      @(negedge clk);
      chk($sformatf("v%0d.pre_valid", k), {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1; in_valid = 1'b1; instr = vecs[k].instr;
      @(negedge clk);
      in_valid = 1'b0;
      chk_outs($sformatf("v%0d", k), vecs[k]);
    end

    // Backpressure: sub x3,x1,x2 held for 3 cycles while a second op waits
    hv.instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, OPR);
    hv.alu = 6'd13; hv.ill = 1'b0; hv.rd = 5'd3; hv.a = X1; hv.b = X2;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = hv.instr;
    @(negedge clk);
    instr = enc_r(7'h00, 5'd5, 5'd9, 3'd6, 5'd21, OPR);
    hs0 = hs_cnt;
    for (int c = 0; c < 3; c++) begin
      chk_outs($sformatf("hold%0d", c), hv);
      chk($sformatf("hold%0d.in_ready", c), {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold.consumed", {63'd0, out_valid}, 64'd0);
    chk("hold.transfers", 64'(hs_cnt - hs0), 64'd1);

    // Write-through bypass: write x7 while accepting add x8,x7,x0
    @(negedge clk);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h55;
    in_valid = 1'b1; instr = enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd8, OPR);
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b0;
    hv.instr = instr; hv.alu = 6'd12; hv.ill = 1'b0; hv.rd = 5'd8; hv.a = 64'h55; hv.b = 64'd0;
    chk_outs("bypass", hv);
    issue(enc_r(7'h00, 5'd7, 5'd0, 3'd0, 5'd8, OPR));
    chk("x7_stored.dataB", data_b, 64'h55);

    // Reset while an output is held
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = enc_i(12'hFFF, 5'd5, 3'd0, 5'd6, OPI);
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst.out_valid", {63'd0, out_valid}, 64'd1);
    chk("prerst.dataA", data_a, X5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2.alu", {58'd0, alu_control}, 64'd0);
    chk("rst2.rd", {59'd0, rd}, 64'd0);
    chk("rst2.illegal", {63'd0, illegal}, 64'd0);
    chk("rst2.dataA", data_a, 64'd0);
    chk("rst2.dataB", data_b, 64'd0);
    chk("rst2.in_ready", {63'd0, in_ready}, 64'd1);
    issue(enc_r(7'h00, 5'd9, 5'd5, 3'd0, 5'd20, OPR));
    chk("rst2.x5", data_a, 64'd0);
    chk("rst2.x9", data_b, 64'd0);
    chk("rst2.valid_after", {63'd0, out_valid}, 64'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
